// File: rtl/deframer_d_demux.sv
// Receive deframer: aligns on COM, strips framing, emits payload with sop/eop.
// Optional DEFRAMER_STATS_EN adds saturating packet/error counters.
module deframer_d_demux #(
  parameter int MAX_LEN = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_sop,
  output logic       out_eop,
  output logic       out_type,
  output logic [7:0] out_len,
`ifdef DEFRAMER_STATS_EN
  output logic [15:0] pkt_count,
  output logic [15:0] err_count,
`endif
  output logic       out_err
);

  localparam logic [7:0] COM = 8'hbc;
  localparam logic [7:0] SKP = 8'h1c;
  localparam logic [7:0] STP = 8'hfb;
  localparam logic [7:0] SDP = 8'h5c;
  localparam logic [7:0] ENDS = 8'hfd;
  localparam logic [7:0] IDL = 8'h7c;
  localparam logic [7:0] MAXL = 8'(MAX_LEN);

  typedef enum logic [1:0] {
    ALIGN, READY, PAYLOAD, DISCARD
  } state_t;

  state_t     st, st_n;
  logic [7:0] len, len_n;
  logic [7:0] hold, hold_n;
  logic       hv, hv_n;
  logic       first, first_n;
  logic       typ, typ_n;
  logic       ov_n, sop_n, eop_n, err_n, ot_n;
  logic [7:0] od_n, ol_n;
  logic       ctrl;

  assign ctrl = (data == COM) || (data == SKP) ||
                (data == STP) || (data == SDP) ||
                (data == ENDS) || (data == IDL);

  // Next-state, hold register and output decode
  always_comb begin
    st_n    = st;
    len_n   = len;
    hold_n  = hold;
    hv_n    = hv;
    first_n = first;
    typ_n   = typ;
    ov_n    = 1'b0;
    sop_n   = 1'b0;
    eop_n   = 1'b0;
    err_n   = 1'b0;
    od_n    = out_data;
    ot_n    = out_type;
    ol_n    = out_len;
    if (valid) begin
      unique case (st)
        ALIGN: begin
          if (data == COM) st_n = READY;
        end
        READY: begin
          if (data == STP || data == SDP) begin
            st_n    = PAYLOAD;
            typ_n   = (data == SDP);
            len_n   = 8'd0;
            hv_n    = 1'b0;
            first_n = 1'b1;
          end else if (data == ENDS || !ctrl) begin
            err_n = 1'b1;
          end
        end
        PAYLOAD: begin
          if (!ctrl) begin
            if (len == MAXL) begin
              err_n = 1'b1;
              hv_n  = 1'b0;
              st_n  = DISCARD;
            end else begin
              len_n  = len + 8'd1;
              hold_n = data;
              hv_n   = 1'b1;
              if (hv) begin
                ov_n    = 1'b1;
                od_n    = hold;
                sop_n   = first;
                ot_n    = typ;
                first_n = 1'b0;
              end
            end
          end else if (data == SKP) begin
            st_n = PAYLOAD;
          end else if (data == ENDS) begin
            if (len != 8'd0) begin
              ov_n  = 1'b1;
              od_n  = hold;
              sop_n = first;
              eop_n = 1'b1;
              ot_n  = typ;
              ol_n  = len;
            end else begin
              err_n = 1'b1;
            end
            hv_n = 1'b0;
            st_n = READY;
          end else begin
            err_n = 1'b1;
            hv_n  = 1'b0;
            st_n  = READY;
          end
        end
        DISCARD: begin
          if (data == ENDS || data == COM) st_n = READY;
        end
        default: st_n = ALIGN;
      endcase
    end
  end

  // State, hold and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= ALIGN;
      len       <= 8'd0;
      hold      <= 8'd0;
      hv        <= 1'b0;
      first     <= 1'b0;
      typ       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_type  <= 1'b0;
      out_len   <= 8'd0;
      out_err   <= 1'b0;
    end else begin
      st        <= st_n;
      len       <= len_n;
      hold      <= hold_n;
      hv        <= hv_n;
      first     <= first_n;
      typ       <= typ_n;
      out_valid <= ov_n;
      out_data  <= od_n;
      out_sop   <= sop_n;
      out_eop   <= eop_n;
      out_type  <= ot_n;
      out_len   <= ol_n;
      out_err   <= err_n;
    end
  end

`ifdef DEFRAMER_STATS_EN
  // Saturating packet and error counters
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count <= 16'd0;
      err_count <= 16'd0;
    end else begin
      if (eop_n && pkt_count != 16'hffff)
        pkt_count <= pkt_count + 16'd1;
      if (err_n && err_count != 16'hffff)
        err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_deframer_d_demux.sv
// Scoreboard bench for deframer_d_demux (MAX_LEN=4).
// Expected output events are queued at stimulus time, popped by a monitor.
module tb_deframer_d_demux;

  localparam logic [7:0] COM = 8'hbc;
  localparam logic [7:0] SKP = 8'h1c;
  localparam logic [7:0] STP = 8'hfb;
  localparam logic [7:0] SDP = 8'h5c;
  localparam logic [7:0] ENDS = 8'hfd;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data = 8'd0;
  logic       out_valid, out_sop, out_eop, out_type, out_err;
  logic [7:0] out_data, out_len;
`ifdef DEFRAMER_STATS_EN
  logic [15:0] pkt_count, err_count;
`endif

  typedef struct packed {
    logic       err;
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       typ;
    logic [7:0] len;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  failures = 0;

  deframer_d_demux #(.MAX_LEN(4)) dut (
    .clk(clk), .reset(reset), .valid(valid), .data(data),
    .out_valid(out_valid), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop),
    .out_type(out_type), .out_len(out_len),
`ifdef DEFRAMER_STATS_EN
    .pkt_count(pkt_count), .err_count(err_count),
`endif
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Monitor: pops one expected event per output pulse
  always @(negedge clk) begin
    if (!reset && (out_valid || out_err)) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected: v=%0b d=%h err=%0b required none",
                 out_valid, out_data, out_err);
      end else begin
        ev_t e;
        logic ok;
        e = q.pop_front();
        if (e.err)
          ok = out_err && !out_valid;
        else
          ok = out_valid && !out_err && out_data == e.d &&
               out_sop == e.sop && out_eop == e.eop &&
               (!e.sop || out_type == e.typ) &&
               (!e.eop || out_len == e.len);
        if (!ok) begin
          failures++;
          $display("FAIL event: got v=%0b err=%0b d=%h sop=%0b eop=%0b t=%0b len=%0d required err=%0b d=%h sop=%0b eop=%0b t=%0b len=%0d",
                   out_valid, out_err, out_data, out_sop, out_eop,
                   out_type, out_len, e.err, e.d, e.sop, e.eop,
                   e.typ, e.len);
        end
      end
    end
  end

  task automatic send(input logic [7:0] s);
    @(posedge clk);
    #1 valid = 1'b1;
    data = s;
  endtask

  task automatic idle_cyc();
    @(posedge clk);
    #1 valid = 1'b0;
    data = 8'h00;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  function automatic ev_t byt(input logic [7:0] d, input logic sop,
                              input logic eop, input logic typ,
                              input logic [7:0] len);
    ev_t e;
    e = '{err: 1'b0, d: d, sop: sop, eop: eop, typ: typ, len: len};
    return e;
  endfunction

  function automatic ev_t errev();
    ev_t e;
    e = '0;
    e.err = 1'b1;
    return e;
  endfunction

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_sop, out_eop, out_type,
         out_len, out_err} != 21'd0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%0b d=%h len=%0d err=%0b required 0",
               out_valid, out_data, out_len, out_err);
    end
    #1 reset = 1'b0;

    // basic STP packet, 3 bytes
    send(COM); send(STP); send(8'h11);
    q.push_back(byt(8'h11, 1, 0, 0, 0)); send(8'h22);
    q.push_back(byt(8'h22, 0, 0, 0, 0)); send(8'h33);
    q.push_back(byt(8'h33, 0, 1, 0, 3)); send(ENDS);
    idle_cyc();

    // unaligned packet dropped, then SDP len 1
    do_reset();
    send(STP); send(8'h11); send(ENDS); send(COM);
    send(SDP); send(8'h44);
    q.push_back(byt(8'h44, 1, 1, 1, 1)); send(ENDS);
    idle_cyc();

    // SKP and invalid cycles inside payload
    send(COM); send(SDP); send(8'ha0); send(SKP);
    idle_cyc(); idle_cyc();
    q.push_back(byt(8'ha0, 1, 0, 1, 0)); send(8'ha1);
    q.push_back(byt(8'ha1, 0, 1, 1, 2)); send(ENDS);
    idle_cyc();

    // nested STP aborts; data and END in READY are errors
    send(COM); send(STP); send(8'h01);
    q.push_back(errev()); send(STP);
    q.push_back(errev()); send(8'h02);
    q.push_back(errev()); send(ENDS);
    idle_cyc();

    // overlong packet at MAX_LEN=4, then recovery
    do_reset();
    send(COM); send(STP); send(8'h01);
    q.push_back(byt(8'h01, 1, 0, 0, 0)); send(8'h02);
    q.push_back(byt(8'h02, 0, 0, 0, 0)); send(8'h03);
    q.push_back(byt(8'h03, 0, 0, 0, 0)); send(8'h04);
    q.push_back(errev()); send(8'h05);
    send(ENDS);
    send(SDP); send(8'h99);
    q.push_back(byt(8'h99, 1, 1, 1, 1)); send(ENDS);
    idle_cyc(); idle_cyc();
`ifdef DEFRAMER_STATS_EN
    @(negedge clk);
    checks++;
    if (pkt_count != 16'd1 || err_count != 16'd1) begin
      failures++;
      $display("FAIL stats: got pkt=%0d err=%0d required pkt=1 err=1",
               pkt_count, err_count);
    end
`endif

    // empty packet, then reset mid-packet
    send(COM); send(STP);
    q.push_back(errev()); send(ENDS);
    send(STP);
    do_reset();
    send(8'h55); send(ENDS);
    repeat (4) idle_cyc();

    // every expected event must have been seen
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL missing_events: got %0d pending required 0",
               q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/deframer_d_demux.md
# deframer_d_demux

Receive-side counterpart to the demux symbol generator: consumes the 8-bit `valid`/`data` symbol stream (COM, SKP, STP, SDP, END, IDL control codes plus data bytes), aligns on COM, strips framing and filler, and delivers packet payload bytes with start/end markers, packet type and length. It sits at the output of the demux lanes and feeds the payload checker in the bench and the downstream logic in the design. Framing violations are reported as one-cycle error pulses.

## Interface
- `COM` 8'hbc: comma, alignment symbol
- `SKP` 8'h1c: skip, filler
- `STP` 8'hfb: start of TLP-type packet
- `SDP` 8'h5c: start of DLLP-type packet
- `END` 8'hfd: end of packet
- `IDL` 8'h7c: idle
- `MAX_LEN` 16: maximum payload bytes per packet (1..255)

- `clk` in 1: clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `valid` in 1: `data` holds a symbol this cycle
- `data` in 8: input symbol
- `out_valid` out 1: payload byte on `out_data`
- `out_data` out 8: payload byte
- `out_sop` out 1: first byte of packet, qualified by `out_valid`
- `out_eop` out 1: last byte of packet, qualified by `out_valid`
- `out_type` out 1: 0 = STP packet, 1 = SDP packet; valid with `out_sop`
- `out_len` out 8: payload length; valid with `out_eop`
- `out_err` out 1: one-cycle framing-error pulse

## Operation
- Cycles with `valid`=0 are ignored: no state, counter or hold-register change.
- Any byte equal to a control code is a control symbol; all other bytes are data.
- States: ALIGN, READY, PAYLOAD, DISCARD. Reset -> ALIGN.
- ALIGN: everything except COM dropped silently, no error; COM -> READY.
- READY: COM, SKP, IDL ignored; STP/SDP -> PAYLOAD, latch type, len=0, hold empty; END or data byte -> `out_err`, stay READY.
- PAYLOAD: data byte -> len+1; if hold occupied, emit held byte (`out_sop` if first emitted), then hold new byte. SKP ignored. END with len>=1 -> emit held byte with `out_eop`=1, `out_len`=len, -> READY. END with len=0 -> `out_err`, -> READY. STP, SDP, COM, IDL -> `out_err`, discard hold, -> READY (offending symbol consumed, does not open a packet).
- Data byte arriving when len=MAX_LEN -> `out_err`, discard hold, -> DISCARD.
- DISCARD: drops everything; END -> READY (no error); COM -> READY.
- An aborted packet may have emitted `out_sop` and bytes without `out_eop`; downstream discards on `out_err`.
- `out_len` is 8 bits; MAX_LEN <= 255 guarantees no wrap.

## Timing
- All outputs registered; reset value 0 for every output; hold register empty.
- Payload byte k appears on outputs the cycle after the edge that accepts byte k+1 (or END for the last byte); it is never emitted earlier.
- `out_valid`, `out_sop`, `out_eop`, `out_err` are single-cycle pulses; `out_data`, `out_type`, `out_len` keep last value otherwise.
- One packet with len=1: `out_sop` and `out_eop` both 1 on the same byte.
- `reset` mid-packet: packet dropped, no `out_eop`, no `out_err`, returns to ALIGN next cycle.

## Configuration
- `DEFRAMER_STATS_EN` defined: adds outputs `pkt_count` out 16 and `err_count` out 16; `pkt_count` +1 on each `out_eop`, `err_count` +1 on each `out_err`; both saturate at 16'hffff, cleared by `reset`.
- Not defined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset, then COM, STP, 11, 22, 33, END -> bytes 11 (sop, type 0), 22, 33 (eop, len 3); `out_err` never 1.
- Reset, then STP, 11, END, COM, SDP, 44, END -> first packet dropped silently; 44 emitted with sop and eop, type 1, len 1.
- COM, SDP, A0, SKP, two cycles `valid`=0, A1, END -> A0 (sop), A1 (eop, len 2); no extra `out_valid`.
- COM, STP, 01, STP, 02, END -> `out_err` one pulse on the second STP; 01 never emitted; 02 and END each raise `out_err` (READY).
- MAX_LEN=4: COM, STP, five data bytes, END -> bytes 1-3 emitted, `out_err` on fifth byte, no `out_eop`, END silent; next SDP, 99, END delivers normally. With `DEFRAMER_STATS_EN`: `pkt_count`=1, `err_count`=1.
- COM, STP, END -> `out_err` pulse, no `out_valid`; assert `reset` between STP and 55, END of another packet -> no output, no error.
